rom_line_cache: RTL and testbench

Direct-mapped, read-only line cache between a 16-bit client (CPU program ROM or sprite/tile fetch) and one 64-bit burst read channel of the SDRAM controller.
- Hits return a 16-bit word without touching SDRAM.
- Misses issue one 4-word burst, fill the line, then answer the client.
- Reduces SDRAM channel occupancy for sequential code fetch.

---
 rtl/rom_line_cache.sv | 186 ++++++++++++++++++
 tb/tb_rom_line_cache.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_line_cache.sv
// rom_line_cache: direct-mapped, read-only line cache between a 16-bit
// client and one 64-bit, 4-word burst read channel of the SDRAM controller.
// Hits answer in one cycle without touching SDRAM. A miss issues one burst,
// fills the indexed line and then answers the client.
//
// Ports:
//   clk         system clock (same domain as the SDRAM controller)
//   reset       asynchronous, active-high reset
//   invalidate  one-cycle pulse, clears every valid bit
//   cpu_addr    client word address [ADDR_W:1], stable while cpu_req is high
//   cpu_req     level request, held until cpu_ack
//   cpu_dout    read data, valid in the ack cycle and held until the next ack
//   cpu_ack     one-cycle pulse completing a request
//   sdr_addr    line-aligned burst address, bits [2:1] always zero
//   sdr_req     burst request level, high for the whole fill
//   sdr_din     burst data, word0 = [15:0] ... word3 = [63:48]
//   sdr_ready   one-cycle pulse, sdr_din valid in the same cycle
//
// Optional feature (define ROMCACHE_STATS_EN):
//   hit_count / miss_count: 16-bit saturating counters of hit acks and of
//   miss fill starts; reset to zero and cleared by invalidate.

module rom_line_cache #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              invalidate,
  input  logic [ADDR_W:1]   cpu_addr,
  input  logic              cpu_req,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W:1]   sdr_addr,
  output logic              sdr_req,
  input  logic [63:0]       sdr_din,
  input  logic              sdr_ready
`ifdef ROMCACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [63:0]        data_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [ADDR_W:1]    lat_addr;
  logic               kill_q;

  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit;
  logic               do_hit, do_miss, do_fill;

  function automatic logic [15:0] sel_word(input logic [63:0] line,
                                           input logic [1:0]  w);
    case (w)
      2'd0:    return line[15:0];
      2'd1:    return line[31:16];
      2'd2:    return line[47:32];
      default: return line[63:48];
    endcase
  endfunction

  assign req_idx  = cpu_addr[3 +: IDX_W];
  assign req_tag  = cpu_addr[ADDR_W:3+IDX_W];
  // The fill targets the address captured at miss time, not the live one.
  assign fill_idx = lat_addr[3 +: IDX_W];
  assign fill_tag = lat_addr[ADDR_W:3+IDX_W];

  assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_fill = 1'b0;
    case (state_q)
      IDLE: begin
        // Holding off while cpu_ack is high spaces acks two cycles apart
        // and keeps sdr_req low for two cycles between bursts.
        if (cpu_req && !cpu_ack) begin
          if (hit) begin
            do_hit = 1'b1;
          end else begin
            do_miss = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (sdr_ready) begin
          do_fill = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cpu_ack  <= 1'b0;
      cpu_dout <= '0;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      lat_addr <= '0;
      kill_q   <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q <= state_d;
      cpu_ack <= do_hit | do_fill;

      if (do_hit) begin
        cpu_dout <= sel_word(data_mem[req_idx], cpu_addr[2:1]);
      end

      if (do_miss) begin
        lat_addr <= cpu_addr;
        sdr_addr <= {cpu_addr[ADDR_W:3], 2'b00};
        sdr_req  <= 1'b1;
      end

      if (do_fill) begin
        sdr_req  <= 1'b0;
        cpu_dout <= sel_word(sdr_din, lat_addr[2:1]);
      end

      // kill remembers an invalidate seen during the fill so the line is
      // delivered to the client but never marked valid.
      if (state_q == FILL && !sdr_ready) begin
        kill_q <= kill_q | invalidate;
      end else begin
        kill_q <= 1'b0;
      end

      if (invalidate) begin
        valid_q <= '0;
      end
      if (do_fill) begin
        valid_q[fill_idx] <= !(kill_q || invalidate);
      end
    end
  end

  // NOTE: line data and tags carry no reset; the valid bits alone decide
  // whether their contents can ever be observed.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_mem[fill_idx] <= sdr_din;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

`ifdef ROMCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (invalidate) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (do_hit && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (do_miss && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rom_line_cache.sv
// Self-checking bench for rom_line_cache. An SDRAM responder answers each
// burst after a chosen latency with data from a fixed address function; a
// line-level model of which line each index holds predicts hit or miss,
// latency, burst count and returned data.

module tb_rom_line_cache;

  localparam int LINES  = 4;
  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              reset;
  logic              invalidate;
  logic [ADDR_W:1]   cpu_addr;
  logic              cpu_req;
  logic [15:0]       cpu_dout;
  logic              cpu_ack;
  logic [ADDR_W:1]   sdr_addr;
  logic              sdr_req;
  logic [63:0]       sdr_din = '0;
  logic              sdr_ready = 1'b0;
`ifdef ROMCACHE_STATS_EN
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;
`endif

  rom_line_cache #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .invalidate (invalidate),
    .cpu_addr   (cpu_addr),
    .cpu_req    (cpu_req),
    .cpu_dout   (cpu_dout),
    .cpu_ack    (cpu_ack),
    .sdr_addr   (sdr_addr),
    .sdr_req    (sdr_req),
    .sdr_din    (sdr_din),
`ifdef ROMCACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .sdr_ready  (sdr_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- backing store and line-level model ----------------
  function automatic logic [63:0] mem_line(input logic [ADDR_W:1] a);
    logic [ADDR_W-1:0] v;
    v = a;
    if (v == 26'h4) return 64'h4444_3333_2222_1111;
    return {v[15:0] ^ 16'hA5C3, v[25:10], v[15:0] + 16'h1357, ~v[15:0]};
  endfunction

  function automatic logic [15:0] model_word(input logic [ADDR_W:1] a);
    logic [63:0]     ln;
    logic [ADDR_W:1] al;
    int              w;
    al = (a >> 2) << 2;
    ln = mem_line(al);
    w  = int'(a & 26'h3);
    return ln[16*w +: 16];
  endfunction

  bit mdl_valid [LINES];
  int mdl_line  [LINES];

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mdl_valid[i] = 1'b0;
  endtask

  // ---------------- shared expectations ----------------
  bit              outstanding = 1'b0;
  logic [15:0]     exp_dout    = '0;
  logic [15:0]     last_exp    = '0;
  logic [ADDR_W:1] exp_sdr     = '0;
  int              next_lat    = 1;

  // ---------------- SDRAM responder ----------------
  int              bursts   = 0;
  int              cnt      = 0;
  bit              prev_req = 1'b0;
  logic [ADDR_W:1] pend_addr = '0;

  always @(negedge clk) begin
    sdr_ready = 1'b0;
    sdr_din   = {$urandom, $urandom};
    if (sdr_req && !prev_req) begin
      bursts++;
      pend_addr = sdr_addr;
      cnt       = next_lat;
    end
    prev_req = sdr_req;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        sdr_ready = 1'b1;
        sdr_din   = mem_line(pend_addr);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_ack) begin
        check("ack_expected", 64'(outstanding), 64'd1);
        check("cpu_dout", 64'(cpu_dout), 64'(exp_dout));
        last_exp = exp_dout;
      end else begin
        check("dout_hold", 64'(cpu_dout), 64'(last_exp));
      end
      if (sdr_req) check("sdr_addr", 64'(sdr_addr), 64'(exp_sdr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_inv();
    @(negedge clk); #1;
    invalidate = 1'b1;
    model_clear();
    @(negedge clk); #1;
    invalidate = 1'b0;
  endtask

  // One client read. with_inv raises invalidate together with the request;
  // inv_mid > 0 pulses invalidate after that many cycles of waiting.
  task automatic do_read(input logic [ADDR_W:1] a, input int lat,
                         input bit with_inv, input int inv_mid,
                         input string name, output logic [15:0] got);
    int cycles, ln, ix, b0;
    bit hit, killed;
    @(negedge clk); #1;
    ln  = int'(a >> 2);
    ix  = ln % LINES;
    hit = mdl_valid[ix] && (mdl_line[ix] == ln);
    exp_dout    = model_word(a);
    exp_sdr     = (a >> 2) << 2;
    next_lat    = lat;
    outstanding = 1'b1;
    b0          = bursts;
    killed      = 1'b0;
    got         = 'x;
    cpu_addr    = a;
    cpu_req     = 1'b1;
    if (with_inv) begin
      invalidate = 1'b1;
      model_clear();
    end
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (cpu_ack) begin
        got = cpu_dout;
        break;
      end
      if (cycles > 200) begin
        check({name, " ack_timeout"}, 64'd0, 64'd1);
        break;
      end
      #1;
      invalidate = (cycles == inv_mid);
      if (invalidate) begin
        model_clear();
        if (!hit) killed = 1'b1;
      end
      // The latched miss address must be used, whatever the bus does now.
      if (!hit && cycles == 1) cpu_addr = ADDR_W'($urandom);
    end
    #1;
    cpu_req     = 1'b0;
    invalidate  = 1'b0;
    outstanding = 1'b0;
    check({name, " latency"}, 64'(cycles), hit ? 64'd1 : 64'(lat + 1));
    check({name, " bursts"},  64'(bursts - b0), hit ? 64'd0 : 64'd1);
    if (!hit && !killed) begin
      mdl_valid[ix] = 1'b1;
      mdl_line[ix]  = ln;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0]     got;
    logic [ADDR_W:1] a;
    int              b0, lat, r, inv_mid;

    reset      = 1'b1;
    invalidate = 1'b0;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    model_clear();

    @(negedge clk); #1;
    check("reset cpu_ack",  64'(cpu_ack),  64'd0);
    check("reset cpu_dout", 64'(cpu_dout), 64'd0);
    check("reset sdr_req",  64'(sdr_req),  64'd0);
    check("reset sdr_addr", 64'(sdr_addr), 64'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Cold miss then three hits in the same line.
    do_read(26'h4, 10, 1'b0, 0, "cold", got);
    check("cold dout literal", 64'(got), 64'h1111);
    check("cold sdr_addr literal", 64'(pend_addr), 64'h4);
    do_read(26'h5, 3, 1'b0, 0, "hit5", got);
    check("hit5 literal", 64'(got), 64'h2222);
    do_read(26'h6, 3, 1'b0, 0, "hit6", got);
    check("hit6 literal", 64'(got), 64'h3333);
    do_read(26'h7, 3, 1'b0, 0, "hit7", got);
    check("hit7 literal", 64'(got), 64'h4444);

    // Conflict eviction on index 0: three bursts.
    b0 = bursts;
    do_read(26'h00, 4, 1'b0, 0, "conf_a", got);
    do_read(26'h20, 5, 1'b0, 0, "conf_b", got);
    do_read(26'h00, 2, 1'b0, 0, "conf_c", got);
    check("conflict burst total", 64'(bursts - b0), 64'd3);

    // Invalidate during a fill: answered, but the line stays invalid.
    do_read(26'h8, 6, 1'b0, 3, "kill_fill", got);
    b0 = bursts;
    do_read(26'h8, 3, 1'b0, 0, "after_kill", got);
    check("after_kill reburst", 64'(bursts - b0), 64'd1);

    // Invalidate in the same cycle as a hit: served, then the line is gone.
    do_read(26'h9, 3, 1'b1, 0, "hit_inv", got);
    b0 = bursts;
    do_read(26'h9, 3, 1'b0, 0, "after_hit_inv", got);
    check("after_hit_inv reburst", 64'(bursts - b0), 64'd1);

    // Reset in the middle of a fill; the late sdr_ready must be ignored.
    @(negedge clk); #1;
    exp_sdr  = 26'h10;
    next_lat = 8;
    cpu_addr = 26'h10;
    cpu_req  = 1'b1;
    repeat (4) @(negedge clk);
    check("mid-fill sdr_req", 64'(sdr_req), 64'd1);
    #1;
    reset       = 1'b1;
    cpu_req     = 1'b0;
    last_exp    = '0;
    model_clear();
    #1;
    check("reset sdr_req drop", 64'(sdr_req), 64'd0);
    check("reset cpu_ack drop", 64'(cpu_ack), 64'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 20 && cnt != 0; i++) @(negedge clk);
    check("stale ready delivered", 64'(cnt), 64'd0);
    repeat (3) @(negedge clk);
    b0 = bursts;
    do_read(26'h10, 4, 1'b0, 0, "after_reset", got);
    check("after_reset reburst", 64'(bursts - b0), 64'd1);

    // Randomized traffic: mostly a small pool of lines for hits and
    // conflicts, occasional far addresses, invalidates and mid-fill kills.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom);
      else                           a = ADDR_W'($urandom_range(0, 63));
      lat = $urandom_range(1, 12);
      r   = $urandom_range(0, 9);
      if (r == 0) pulse_inv();
      inv_mid = (r == 1) ? $urandom_range(1, lat) : 0;
      do_read(a, lat, 1'b0, inv_mid, "rand", got);
    end

`ifdef ROMCACHE_STATS_EN
    pulse_inv();
    check("stats clear hit",  64'(hit_count),  64'd0);
    check("stats clear miss", 64'(miss_count), 64'd0);
    do_read(26'h4, 5, 1'b0, 0, "st_miss", got);
    do_read(26'h5, 2, 1'b0, 0, "st_hit1", got);
    do_read(26'h6, 2, 1'b0, 0, "st_hit2", got);
    do_read(26'h7, 2, 1'b0, 0, "st_hit3", got);
    check("stats hit_count",  64'(hit_count),  64'd3);
    check("stats miss_count", 64'(miss_count), 64'd1);
    pulse_inv();
    check("stats inv hit",  64'(hit_count),  64'd0);
    check("stats inv miss", 64'(miss_count), 64'd0);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
